// File: rtl/mailbox_msg_reader_if.sv
// Signal bundle between the message reader, the mailbox it reads from and
// the downstream consumer of the word stream.
// slave  : the reader itself.
// master : the surrounding environment (requester, mailbox, consumer).
interface mailbox_msg_reader_if;
  // request side
  logic        start;
  logic [3:0]  msg_len;
  // mailbox read port
  logic        mbx_rd;
  logic [2:0]  mbx_rd_sel;
  logic [31:0] mbx_rdata;
  logic        mbx_rvalid;
  // word stream
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  // status
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  start,
    input  msg_len,
    output mbx_rd,
    output mbx_rd_sel,
    input  mbx_rdata,
    input  mbx_rvalid,
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready,
    output busy,
    output done,
    output err
  );

  modport master (
    output start,
    output msg_len,
    input  mbx_rd,
    input  mbx_rd_sel,
    output mbx_rdata,
    output mbx_rvalid,
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready,
    input  busy,
    input  done,
    input  err
  );
endinterface

// File: rtl/mailbox_msg_reader.sv
// Mailbox message reader: on start, reads up to MESSAGE_DEPTH 32-bit words
// from a mailbox one at a time and streams them out with valid/ready,
// marking the final word with m_last. A missing read-valid aborts the
// message into ERR and raises a sticky err flag.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; msg_len is sampled here only
// READ  | one-cycle mailbox read of word idx
// OUT   | word held on m_data with m_valid until the consumer takes it
// FIN   | message complete, done pulse
// ERR   | mailbox did not answer, err set, done pulse
module mailbox_msg_reader #(
  parameter int MESSAGE_DEPTH = 1
) (
  input logic                  clk,
  input logic                  reset,
  mailbox_msg_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    OUT  = 3'd2,
    FIN  = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [3:0] DEPTH = 4'(MESSAGE_DEPTH);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  idx_q;
  logic [3:0]  len_q;
  logic [2:0]  sel_q;
  logic [31:0] data_q;
  logic        err_q;

  logic [3:0]  len_clamped;
  logic        last_word;
  logic        start_accept;
  logic        out_accept;

  // Requested length limited to the words the mailbox actually holds.
  assign len_clamped  = (bus.msg_len > DEPTH) ? DEPTH : bus.msg_len;

  // len is at least 1 whenever OUT is reachable, so len-1 never underflows there.
  assign last_word    = ({1'b0, idx_q} == (len_q - 4'd1));

  assign start_accept = (state_q == IDLE) && bus.start;
  assign out_accept   = (state_q == OUT) && bus.m_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.msg_len == 4'd0) ? FIN : READ;
        end
      end
      READ: begin
        state_d = bus.mbx_rvalid ? OUT : ERR;
      end
      OUT: begin
        if (bus.m_ready) begin
          state_d = last_word ? FIN : READ;
        end
      end
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Message bookkeeping: length, word index, and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= 3'd0;
      len_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      if (start_accept) begin
        idx_q <= 3'd0;
        len_q <= len_clamped;
        err_q <= 1'b0;
      end
      if ((state_q == READ) && !bus.mbx_rvalid) begin
        err_q <= 1'b1;
      end
      // Index only advances on a non-final handshake, so it tops out at len-1.
      if (out_accept && !last_word) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  // Read-side registers: captured word and the last index presented to the mailbox.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q  <= 3'd0;
      data_q <= 32'd0;
    end else if (state_q == READ) begin
      sel_q <= idx_q;
      if (bus.mbx_rvalid) begin
        data_q <= bus.mbx_rdata;
      end
    end
  end

  // Outputs are decoded from registered state so they drop with reset at once.
  // mbx_rd_sel shows idx while reading and otherwise keeps the last index read.
  always_comb begin
    bus.mbx_rd     = (state_q == READ);
    bus.mbx_rd_sel = (state_q == READ) ? idx_q : sel_q;
    bus.m_data     = data_q;
    bus.m_valid    = (state_q == OUT);
    bus.m_last     = (state_q == OUT) && last_word;
    bus.busy       = (state_q != IDLE);
    bus.done       = (state_q == FIN) || (state_q == ERR);
    bus.err        = err_q;
  end

endmodule
